// File: rtl/axis_pkg.sv
// Shared defaults and the beat layout for the AXI-Stream FIFO.
package axis_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int DEPTH_DEF  = 16;

  // One stored beat. The RAM word is laid out as {tlast, tdata} to match this struct.
  typedef struct packed {
    logic                  tlast;
    logic [DATA_W_DEF-1:0] tdata;
  } axis_beat_t;

endpackage

// File: rtl/axis_fifo_ram.sv
// Storage array for the FIFO: synchronous write, asynchronous read.
module axis_fifo_ram #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Write the addressed word on an accepted beat.
  // NOTE: the array has no reset; the FIFO pointers decide which words are valid, and a reset would block RAM inference.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/axis_fifo.sv
// First-word-fall-through AXI-Stream FIFO with beat level and packet count.
module axis_fifo
  import axis_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic [DATA_W-1:0]        s_axis_tdata,
  input  logic                     s_axis_tvalid,
  input  logic                     s_axis_tlast,
  output logic                     s_axis_tready,
  output logic [DATA_W-1:0]        m_axis_tdata,
  output logic                     m_axis_tvalid,
  output logic                     m_axis_tlast,
  input  logic                     m_axis_tready,
  output logic [$clog2(DEPTH):0]   level,
  output logic [$clog2(DEPTH):0]   pkt_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int BW = DATA_W + 1;

  // Pointers carry one extra wrap bit so full and empty differ only in the MSB.
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] pkt_cnt_q, pkt_cnt_d;
  // Holds s_axis_tready low from reset until the first clock edge after release.
  logic          rst_done_q;

  logic          full;
  logic          empty;
  logic          wr_en;
  logic          rd_en;
  logic [BW-1:0] rd_word;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // Ready depends only on registered state, never on m_axis_tready, so a pop
  // while full cannot admit a push in the same cycle.
  assign s_axis_tready = rst_done_q & ~full;
  assign m_axis_tvalid = ~empty;

  assign wr_en = s_axis_tvalid & s_axis_tready;
  assign rd_en = m_axis_tvalid & m_axis_tready;

  // Output data is forced to zero while empty so stale RAM contents never show.
  assign m_axis_tdata = m_axis_tvalid ? rd_word[DATA_W-1:0] : '0;
  assign m_axis_tlast = m_axis_tvalid & rd_word[DATA_W];

  assign level   = wr_ptr_q - rd_ptr_q;
  assign pkt_cnt = pkt_cnt_q;

  axis_fifo_ram #(
    .WIDTH (BW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk_i   (aclk),
    .we_i    (wr_en),
    .waddr_i (wr_ptr_q[AW-1:0]),
    .wdata_i ({s_axis_tlast, s_axis_tdata}),
    .raddr_i (rd_ptr_q[AW-1:0]),
    .rdata_o (rd_word)
  );

  // Next-state for pointers and the stored-packet count.
  // NOTE: every output gets a default first so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    pkt_cnt_d = pkt_cnt_q;
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({wr_en & s_axis_tlast, rd_en & m_axis_tlast})
      2'b10:   pkt_cnt_d = pkt_cnt_q + PW'(1);
      2'b01:   pkt_cnt_d = pkt_cnt_q - PW'(1);
      default: pkt_cnt_d = pkt_cnt_q;
    endcase
  end

  // State registers; reset discards all stored beats.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      pkt_cnt_q  <= '0;
      rst_done_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      pkt_cnt_q  <= pkt_cnt_d;
      rst_done_q <= 1'b1;
    end
  end

endmodule

// File: doc/axis_fifo.md
AXIS_FIFO -- requirements
Module: axis_fifo

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning the tdata width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 16, meaning the number of stored beats (power of 2, at least 2).
REQ-003 The block SHALL have port aclk, input, 1, meaning the single clock; all logic on its rising edge.
REQ-004 The block SHALL have port aresetn, input, 1, meaning the asynchronous active-low reset.
REQ-005 The block SHALL have port s_axis_tdata, input, DATA_W, meaning the slave data.
REQ-006 The block SHALL have port s_axis_tvalid, input, 1, meaning the slave valid.
REQ-007 The block SHALL have port s_axis_tlast, input, 1, meaning the slave end-of-packet.
REQ-008 The block SHALL have port s_axis_tready, output, 1, meaning the slave ready.
REQ-009 The block SHALL have port m_axis_tdata, output, DATA_W, meaning the master data.
REQ-010 The block SHALL have port m_axis_tvalid, output, 1, meaning the master valid.
REQ-011 The block SHALL have port m_axis_tlast, output, 1, meaning the master end-of-packet.
REQ-012 The block SHALL have port m_axis_tready, input, 1, meaning the master ready.
REQ-013 The block SHALL have port level, output, $clog2(DEPTH)+1, meaning the beats currently stored.
REQ-014 The block SHALL have port pkt_cnt, output, $clog2(DEPTH)+1, meaning the complete packets (stored tlast beats) currently held.

Function
REQ-015 Write handshake SHALL occur when s_axis_tvalid and s_axis_tready are both high at a clock edge; {tlast, tdata} SHALL be stored at the write pointer, and the pointer SHALL increment modulo DEPTH.
REQ-016 Read handshake SHALL occur when m_axis_tvalid and m_axis_tready are both high at a clock edge; the read pointer SHALL increment modulo DEPTH.
REQ-017 s_axis_tready SHALL be high exactly when level is below DEPTH; it SHALL be a registered or pointer-derived function with no combinational path from m_axis_tready.
REQ-018 m_axis_tvalid SHALL be high exactly when level is above 0; m_axis_tdata and m_axis_tlast SHALL present the oldest stored beat (first-word-fall-through).
REQ-019 Latency SHALL be 1 cycle: a beat written at edge N SHALL appear on the master side after edge N; no same-cycle write-through.
REQ-020 Once m_axis_tvalid is asserted, m_axis_tvalid, m_axis_tdata and m_axis_tlast SHALL stay stable until the read handshake.
REQ-021 level SHALL change as follows: +1 on write only, -1 on read only, unchanged on simultaneous write and read.
REQ-022 pkt_cnt SHALL change as follows: +1 on a write with tlast, -1 on a read with tlast, unchanged when both occur in one cycle.
REQ-023 When full, a simultaneous read SHALL NOT enable a write in the same cycle; the write SHALL be accepted the next cycle.
REQ-024 Pointers SHALL be $clog2(DEPTH)+1 bits so that full and empty are distinguished by the MSB.
REQ-025 An input with tvalid low SHALL never alter state, regardless of tdata and tlast.

Reset
REQ-026 Asserting aresetn low SHALL immediately clear both pointers, level and pkt_cnt, and drive s_axis_tready=0 and m_axis_tvalid=0.
REQ-027 After release, s_axis_tready SHALL rise at the first clock edge.
REQ-028 Reset mid-packet SHALL discard all stored beats; memory contents need no reset.

Structure
REQ-029 DATA_W and DEPTH defaults and the beat struct {tlast, tdata} SHALL live in axis_pkg.
REQ-030 Storage SHALL be a sub-module axis_fifo_ram: one synchronous write port, one asynchronous read port, DEPTH x (DATA_W+1).

Verification
REQ-031 The bench SHALL cover single beat: write 0xA5A5A5A5 with tlast=1 at edge N, then m_axis_tvalid=1 after N, level=1 and pkt_cnt=1; read yields level=0 and pkt_cnt=0.
REQ-032 The bench SHALL cover fill: 16 writes with m_axis_tready=0, then s_axis_tready=0 and level=16; a 17th beat is held off and the 16 beats read in order 0..15.
REQ-033 The bench SHALL cover streaming: both sides always ready, 100 beats 0..99 pass in order at 1 beat/cycle, and level stays 1 after the first write.
REQ-034 The bench SHALL cover backpressure stability: m_axis_tready toggling randomly, with tdata and tlast never changing while tvalid is high and not yet accepted.
REQ-035 The bench SHALL cover packets: three packets of lengths 1, 4 and 7 written, then pkt_cnt=3 and level=12; reading 5 beats gives pkt_cnt=1.
REQ-036 The bench SHALL cover mid-reset: aresetn pulsed low with level=9, then all outputs are zero asynchronously, and after release the next written beat 0x1 is the first beat read.
